// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder bit per clock, LSB first, through IDLE -> RUN -> DONE.
// sum/cout are registered and hold the last completed result until the next DONE.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       fsm_state
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             bit_s, carry_next, last_bit;

  assign bit_s      = a_sr[0] ^ b_sr[0] ^ carry;
  assign carry_next = (a_sr[0] & b_sr[0]) | (carry & (a_sr[0] ^ b_sr[0]));
  assign last_bit   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_bit) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operands shift right, the new sum bit enters at the MSB of res_sr.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {bit_s, res_sr[WIDTH-1:1]};
          carry  <= carry_next;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= {bit_s, res_sr[WIDTH-1:1]};
            cout <= carry_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign fsm_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: WIDTH=8 vectors, continuous start, mid-run reset,
// and an exhaustive sweep of a second WIDTH=2 instance.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst, start, cin;
  logic [7:0] a, b, sum;
  logic       busy, done, cout;
  logic [1:0] fsm_state;

  logic       start2, cin2, busy2, done2, cout2;
  logic [1:0] a2, b2, sum2, fsm_state2;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] exp_q[$];
  logic [8:0] prev_res = 9'h000;

  // Handshake: start is a request sampled only while idle; done is a one-cycle
  // pulse and sum/cout are valid in that cycle and held afterwards.
  serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .fsm_state(fsm_state)
  );

  serial_adder #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .fsm_state(fsm_state2)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One WIDTH=8 addition with a hand-computed {cout,sum}.
  task automatic run_add8(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                          input logic tc, input logic [8:0] exp_full, input bit scramble);
    int cyc = 0;
    int busy_cnt = 0;
    bit seen = 0;
    logic [8:0] e;
    exp_q.push_back(exp_full);
    @(negedge clk);
    start = 1'b1; a = ta; b = tb; cin = tc;
    @(posedge clk);
    #1;
    start = 1'b0;
    if (scramble) begin
      a = 8'($urandom_range(255));
      b = 8'($urandom_range(255));
      cin = 1'($urandom_range(1));
    end
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (busy) busy_cnt++;
      if (cyc == 4) check({tag, "_hold"}, {23'd0, cout, sum}, {23'd0, prev_res});
      if (cyc == 5 && scramble) begin
        a = 8'($urandom_range(255));
        b = 8'($urandom_range(255));
        cin = 1'($urandom_range(1));
      end
      if (done) seen = 1;
    end
    e = exp_q.pop_front();
    check({tag, "_latency"}, cyc, 9);
    check({tag, "_busy_cycles"}, busy_cnt, 9);
    check({tag, "_sum"}, {24'd0, sum}, {24'd0, e[7:0]});
    check({tag, "_cout"}, {31'd0, cout}, {31'd0, e[8]});
    prev_res = e;
    @(negedge clk);
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int cyc, last, pulses, stray;
    bit seen;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {23'd0, cout, sum}, 32'd0);
    check("rst_state", {30'd0, fsm_state}, 32'd0);
    rst = 1'b0;

    run_add8("zero", 8'h00, 8'h00, 1'b0, 9'h000, 0);
    run_add8("ff_plus_1", 8'hFF, 8'h01, 1'b0, 9'h100, 0);
    run_add8("7f_plus_1", 8'h7F, 8'h01, 1'b0, 9'h080, 0);
    run_add8("a5_5a_cin", 8'hA5, 8'h5A, 1'b1, 9'h100, 1);
    run_add8("mixed", 8'h3C, 8'h99, 1'b1, 9'h0D6, 1);

    // start held high: one accepted every WIDTH+2 cycles
    @(negedge clk);
    start = 1'b1; a = 8'h03; b = 8'h04; cin = 1'b0;
    cyc = 0; last = 0; pulses = 0;
    while (cyc < 45) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        if (last > 0) check("cont_period", cyc - last, 10);
        check("cont_sum", {23'd0, cout, sum}, 32'h007);
        last = cyc;
        pulses++;
      end
    end
    start = 1'b0;
    check("cont_pulses", pulses, 4);
    repeat (12) @(negedge clk);
    check("cont_drained", {31'd0, busy}, 32'd0);
    prev_res = 9'h007;

    // reset at the 4th RUN edge aborts the addition with no done
    @(negedge clk);
    start = 1'b1; a = 8'h0F; b = 8'h0F; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", {23'd0, cout, sum}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0; start = 1'b0;
    stray = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) stray++;
    end
    check("abort_no_done", stray, 0);
    prev_res = 9'h000;
    run_add8("after_abort", 8'h0F, 8'h0F, 1'b0, 9'h01E, 0);

    // exhaustive WIDTH=2
    for (int ai = 0; ai < 4; ai++)
      for (int bi = 0; bi < 4; bi++)
        for (int ci = 0; ci < 2; ci++) begin
          @(negedge clk);
          start2 = 1'b1; a2 = 2'(ai); b2 = 2'(bi); cin2 = 1'(ci);
          @(posedge clk);
          #1;
          start2 = 1'b0;
          cyc = 0; seen = 0;
          while (!seen && cyc < 10) begin
            @(negedge clk);
            cyc++;
            if (done2) seen = 1;
          end
          check($sformatf("w2_lat_%0d_%0d_%0d", ai, bi, ci), cyc, 3);
          check($sformatf("w2_%0d_%0d_%0d", ai, bi, ci), {29'd0, cout2, sum2}, 32'(ai + bi + ci));
        end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
